// File: rtl/sap_control_sequencer.sv
// ---------------------------------------------------------------------------
// sap_control_sequencer
//
// Purpose:
//   T-state ring sequencer and instruction decoder for the SAP-BR datapath.
//   A fixed six-state cycle (T1-T3 fetch, T4-T6 execute) drives the bus
//   load/enable strobes and the ALU controls from the IR opcode nibble.
//
// Optional build macro:
//   SAP_STEP_EN - adds a single-step input 'step'. The ring advances only on
//                 edges where step=1, and every strobe except hlt is qualified
//                 by step, so each T-state word fires once per pulse.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   step     in   single-step pulse (SAP_STEP_EN builds only)
//   opcode   in   [OPC_W-1:0] opcode nibble from the IR
//   t_state  out  [5:0] one-hot T-state, bit0 = T1 ... bit5 = T6
//   cp,ep,lm,ce,li,ei,la,ea,lb,lo          out  datapath strobes
//   sub,not_op,al0,al1,alu_out             out  ALU controls
//   hlt      out  halted flag
// ---------------------------------------------------------------------------
module sap_control_sequencer #(
    parameter int OPC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SAP_STEP_EN
    input  logic             step,
`endif
    input  logic [OPC_W-1:0] opcode,
    output logic [5:0]       t_state,
    output logic             cp,
    output logic             ep,
    output logic             lm,
    output logic             ce,
    output logic             li,
    output logic             ei,
    output logic             la,
    output logic             ea,
    output logic             lb,
    output logic             lo,
    output logic             sub,
    output logic             not_op,
    output logic             al0,
    output logic             al1,
    output logic             alu_out,
    output logic             hlt
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'b0000);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'b0001);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'b0010);
    localparam logic [OPC_W-1:0] OP_AND = OPC_W'(4'b0011);
    localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(4'b0100);
    localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4'b0101);
    localparam logic [OPC_W-1:0] OP_NOT = OPC_W'(4'b0110);
    localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'b1110);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'b1111);

    t_state_e state_q, state_d;
    logic     halted_q, halted_d;
    logic     advance_s;
    logic     strobe_en_s;

    logic cp_s, ep_s, lm_s, ce_s, li_s, ei_s, la_s, ea_s, lb_s, lo_s;
    logic sub_s, not_op_s, al0_s, al1_s, alu_out_s;

`ifdef SAP_STEP_EN
    assign advance_s = step;
`else
    assign advance_s = 1'b1;
`endif

    // Halt blanks every strobe; in step builds strobes also need a step pulse.
    assign strobe_en_s = ~halted_q & advance_s;

    // State and halt flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= T1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Next-state ring and halt capture; halt freezes the ring at T5.
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (halted_q) begin
            state_d = state_q;
        end else if (advance_s) begin
            case (state_q)
                T1:      state_d = T2;
                T2:      state_d = T3;
                T3:      state_d = T4;
                T4:      state_d = T5;
                T5:      state_d = T6;
                T6:      state_d = T1;
                default: state_d = T1;
            endcase
            // The flag lands on the same edge that moves T4 to T5.
            if ((state_q == T4) && (opcode == OP_HLT)) begin
                halted_d = 1'b1;
            end else begin
                halted_d = halted_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Raw control word for the current T-state; opcode only matters in T4-T6.
    always_comb begin
        cp_s = 1'b0; ep_s = 1'b0; lm_s = 1'b0; ce_s = 1'b0; li_s = 1'b0;
        ei_s = 1'b0; la_s = 1'b0; ea_s = 1'b0; lb_s = 1'b0; lo_s = 1'b0;
        sub_s = 1'b0; not_op_s = 1'b0; al0_s = 1'b0; al1_s = 1'b0;
        alu_out_s = 1'b0;
        case (state_q)
            T1: begin ep_s = 1'b1; lm_s = 1'b1; end
            T2: begin cp_s = 1'b1; end
            T3: begin ce_s = 1'b1; li_s = 1'b1; end
            T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        ei_s = 1'b1;
                        lm_s = 1'b1;
                    end
                    OP_NOT: begin
                        alu_out_s = 1'b1;
                        la_s      = 1'b1;
                        al1_s     = 1'b1;
                        al0_s     = 1'b1;
                        not_op_s  = 1'b1;
                    end
                    OP_OUT: begin
                        ea_s = 1'b1;
                        lo_s = 1'b1;
                    end
                    default: begin end
                endcase
            end
            T5: begin
                case (opcode)
                    OP_LDA: begin
                        ce_s = 1'b1;
                        la_s = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        ce_s = 1'b1;
                        lb_s = 1'b1;
                    end
                    default: begin end
                endcase
            end
            T6: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        alu_out_s = 1'b1;
                        la_s      = 1'b1;
                        sub_s     = (opcode == OP_SUB);
                        al0_s     = (opcode == OP_AND) || (opcode == OP_XOR);
                        al1_s     = (opcode == OP_OR)  || (opcode == OP_XOR);
                    end
                    default: begin end
                endcase
            end
            default: begin end
        endcase
    end

    assign t_state = state_q;
    assign cp      = cp_s      & strobe_en_s;
    assign ep      = ep_s      & strobe_en_s;
    assign lm      = lm_s      & strobe_en_s;
    assign ce      = ce_s      & strobe_en_s;
    assign li      = li_s      & strobe_en_s;
    assign ei      = ei_s      & strobe_en_s;
    assign la      = la_s      & strobe_en_s;
    assign ea      = ea_s      & strobe_en_s;
    assign lb      = lb_s      & strobe_en_s;
    assign lo      = lo_s      & strobe_en_s;
    assign sub     = sub_s     & strobe_en_s;
    assign not_op  = not_op_s  & strobe_en_s;
    assign al0     = al0_s     & strobe_en_s;
    assign al1     = al1_s     & strobe_en_s;
    assign alu_out = alu_out_s & strobe_en_s;
    assign hlt     = halted_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sap_control_sequencer
//
// Self-checking bench for sap_control_sequencer. Each cycle the bench drives
// rst/opcode (and step in SAP_STEP_EN builds), pushes the expected control
// word from its own T-state/halt model into a queue, then pops it and compares
// against the DUT outputs mid-cycle, well away from the rising edge.
// Word layout: {t_state[5:0], cp,ep,lm,ce,li,ei,la,ea,lb,lo,
//               sub,not_op,al0,al1,alu_out,hlt}
// ---------------------------------------------------------------------------
module tb_sap_control_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'h0;
`ifdef SAP_STEP_EN
    logic       step = 1'b0;
`endif
    logic [5:0] t_state;
    logic cp, ep, lm, ce, li, ei, la, ea, lb, lo;
    logic sub, not_op, al0, al1, alu_out, hlt;

    logic [21:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          m_state = 0;     // model T-state index, 0 = T1
    bit          m_halt  = 1'b0;
    bit          m_valid = 1'b0;  // model known once a reset edge has happened
    int          cp_cnt  = 0;

    sap_control_sequencer #(.OPC_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef SAP_STEP_EN
        .step    (step),
`endif
        .opcode  (opcode),
        .t_state (t_state),
        .cp      (cp),
        .ep      (ep),
        .lm      (lm),
        .ce      (ce),
        .li      (li),
        .ei      (ei),
        .la      (la),
        .ea      (ea),
        .lb      (lb),
        .lo      (lo),
        .sub     (sub),
        .not_op  (not_op),
        .al0     (al0),
        .al1     (al1),
        .alu_out (alu_out),
        .hlt     (hlt)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expectation and count the result.
    task automatic check_eq(input string tag, input logic [21:0] obs, input logic [21:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference control word for a model state, written from the opcode table.
    function automatic logic [21:0] exp_word(input int ms, input bit mh,
                                             input logic [3:0] op, input bit st);
        logic e_cp, e_ep, e_lm, e_ce, e_li, e_ei, e_la, e_ea, e_lb, e_lo;
        logic e_sub, e_not, e_al0, e_al1, e_alu;
        logic [5:0] t;
        {e_cp, e_ep, e_lm, e_ce, e_li, e_ei, e_la, e_ea, e_lb, e_lo} = 10'b0;
        {e_sub, e_not, e_al0, e_al1, e_alu} = 5'b0;
        t = 6'b000001 << ms;
        if (!mh && st) begin
            case (ms)
                0: begin e_ep = 1'b1; e_lm = 1'b1; end
                1: e_cp = 1'b1;
                2: begin e_ce = 1'b1; e_li = 1'b1; end
                3: begin
                    if (op <= 4'h5) begin
                        e_ei = 1'b1; e_lm = 1'b1;
                    end else if (op == 4'h6) begin
                        e_alu = 1'b1; e_la = 1'b1; e_al1 = 1'b1; e_al0 = 1'b1; e_not = 1'b1;
                    end else if (op == 4'hE) begin
                        e_ea = 1'b1; e_lo = 1'b1;
                    end
                end
                4: begin
                    if (op == 4'h0) begin
                        e_ce = 1'b1; e_la = 1'b1;
                    end else if (op <= 4'h5) begin
                        e_ce = 1'b1; e_lb = 1'b1;
                    end
                end
                5: begin
                    if (op >= 4'h1 && op <= 4'h5) begin
                        e_alu = 1'b1; e_la = 1'b1;
                        e_sub = (op == 4'h2);
                        e_al0 = (op == 4'h3) || (op == 4'h5);
                        e_al1 = (op == 4'h4) || (op == 4'h5);
                    end
                end
                default: begin end
            endcase
        end
        return {t, e_cp, e_ep, e_lm, e_ce, e_li, e_ei, e_la, e_ea, e_lb, e_lo,
                e_sub, e_not, e_al0, e_al1, e_alu, mh};
    endfunction

    // One clock cycle: drive, push expectation, sample, compare, step the model.
    task automatic cycle(input string tag, input logic r, input logic [3:0] op, input bit st);
        logic [21:0] obs;
        logic [21:0] e;
        logic        excl_ok;
        @(posedge clk);
        #1;
        rst    = r;
        opcode = op;
`ifdef SAP_STEP_EN
        step   = st;
`endif
        if (m_valid) exp_q.push_back(exp_word(m_state, m_halt, op, st));
        #2;
        obs = {t_state, cp, ep, lm, ce, li, ei, la, ea, lb, lo,
               sub, not_op, al0, al1, alu_out, hlt};
        if (m_valid) begin
            e = exp_q.pop_front();
            check_eq(tag, obs, e);
            excl_ok = ($countones({ep, ce, ei, ea, alu_out}) <= 1);
            check_eq("bus_excl", {21'd0, excl_ok}, 22'd1);
            if (cp === 1'b1) cp_cnt++;
        end
        if (r) begin
            m_state = 0;
            m_halt  = 1'b0;
            m_valid = 1'b1;
        end else if (!m_halt && st) begin
            if (m_state == 3 && op == 4'hF) m_halt = 1'b1;
            m_state = (m_state + 1) % 6;
        end
    endtask

    // Full six-cycle instruction from T1; fetch cycles see a random opcode.
    task automatic run_instr(input string tag, input logic [3:0] op);
        for (int i = 0; i < 6; i++) begin
            if (i < 3) cycle(tag, 1'b0, 4'($urandom_range(15, 0)), 1'b1);
            else       cycle(tag, 1'b0, op, 1'b1);
        end
    endtask

    initial begin
        logic [3:0] ops [11];
        ops = '{4'h2, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'hE, 4'h0, 4'h7, 4'h8, 4'hD};

        // Two reset cycles, then one full ring pass.
        cycle("reset", 1'b1, 4'h0, 1'b1);
        cycle("reset", 1'b1, 4'h0, 1'b1);
        for (int i = 0; i < 6; i++) cycle("ring", 1'b0, 4'h0, 1'b1);

        // Every opcode class, including NOPs.
        foreach (ops[i]) run_instr($sformatf("op%h", ops[i]), ops[i]);

        // XOR aborted by reset during T5.
        for (int i = 0; i < 4; i++) cycle("xor_abort", 1'b0, 4'h5, 1'b1);
        cycle("xor_abort_rst", 1'b1, 4'h5, 1'b1);
        run_instr("after_abort", 4'h0);

        // Halt: hlt stays low in T4, then frozen for 20 cycles, reset exits.
        for (int i = 0; i < 4; i++) cycle("hlt_entry", 1'b0, 4'hF, 1'b1);
        for (int i = 0; i < 20; i++) cycle("halted", 1'b0, 4'($urandom_range(15, 0)), 1'b1);
        cycle("halt_rst", 1'b1, 4'h0, 1'b1);
        run_instr("after_halt", 4'h1);

`ifdef SAP_STEP_EN
        // Step pulses every fourth cycle: one T-state per pulse, cp fires once.
        cycle("step_rst", 1'b1, 4'h0, 1'b1);
        cp_cnt = 0;
        for (int i = 0; i < 24; i++) cycle("step", 1'b0, 4'h0, (i % 4) == 3);
        check_eq("cp_once", 22'(cp_cnt), 22'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
